// File: rtl/bw_pipe.sv
// Backward-registered two-entry valid/ready slice: every output (s_ready,
// m_valid, m_data, count) comes straight from a flop, cutting the ready path.
module bw_pipe #(
    parameter int WD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [WD-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [WD-1:0] m_data,
    input  logic          m_ready,
    output logic [1:0]    count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [WD-1:0] out_q, skid_q;
    logic          m_valid_q, s_ready_q;

    logic push, pop;
    logic load_out, out_from_skid, load_skid;

    assign push = s_valid & s_ready_q;
    assign pop  = m_valid_q & m_ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    load_out = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (push && pop) begin
                    load_out = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // s_ready is low here, so only the drain side can move
                if (pop) begin
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                    state_d       = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_out)
                out_q <= out_from_skid ? skid_q : s_data;
            if (load_skid)
                skid_q <= s_data;
            // Handshake flags are registered from next-state, so they line up
            // with the occupancy the flops will hold after this edge.
            m_valid_q <= (state_d != EMPTY);
            s_ready_q <= (state_d != FULL);
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = out_q;
    assign count   = state_q;

endmodule

// File: tb/tb_bw_pipe.sv
// Directed vector table, streaming sequence and random-stall scoreboard for bw_pipe.
module tb_bw_pipe;

    localparam int WD = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [WD-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [WD-1:0] m_data;
    logic          m_ready;
    logic [1:0]    count;

    int checks   = 0;
    int failures = 0;

    bw_pipe #(.WD(WD)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .count   (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          sv;
        logic [WD-1:0] sd;
        logic          mr;
        logic [1:0]    e_cnt;
        logic          e_mv;
        logic          e_sr;
        logic          chk_md;
        logic [WD-1:0] e_md;
    } vec_t;

    task automatic chk(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[16];

    initial begin
        // rst sv  data      mr  cnt mv sr chkmd md
        vt[0]  = '{1, 0, 32'h00, 0, 0, 0, 0, 1, 32'h00};
        vt[1]  = '{1, 1, 32'h99, 1, 0, 0, 0, 1, 32'h00};
        vt[2]  = '{1, 0, 32'h00, 0, 0, 0, 0, 1, 32'h00};
        vt[3]  = '{0, 0, 32'h00, 0, 0, 0, 1, 1, 32'h00};
        vt[4]  = '{0, 1, 32'hA0, 1, 1, 1, 1, 1, 32'hA0};
        vt[5]  = '{0, 1, 32'hA1, 0, 2, 1, 0, 1, 32'hA0};
        vt[6]  = '{0, 1, 32'hA2, 0, 2, 1, 0, 1, 32'hA0};
        vt[7]  = '{0, 1, 32'hA2, 1, 1, 1, 1, 1, 32'hA1};
        vt[8]  = '{0, 1, 32'hA2, 1, 1, 1, 1, 1, 32'hA2};
        vt[9]  = '{0, 0, 32'h00, 1, 0, 0, 1, 0, 32'h00};
        vt[10] = '{0, 1, 32'h55, 0, 1, 1, 1, 1, 32'h55};
        vt[11] = '{0, 1, 32'h66, 0, 2, 1, 0, 1, 32'h55};
        vt[12] = '{1, 0, 32'h00, 0, 0, 0, 0, 1, 32'h00};
        vt[13] = '{0, 1, 32'h77, 0, 0, 0, 1, 0, 32'h00};
        vt[14] = '{0, 1, 32'h77, 0, 1, 1, 1, 1, 32'h77};
        vt[15] = '{0, 0, 32'h00, 1, 0, 0, 1, 0, 32'h00};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        #1;

        // Reset, skid/release and mid-reset sequences
        foreach (vt[i]) begin
            rst = vt[i].rst; s_valid = vt[i].sv; s_data = vt[i].sd; m_ready = vt[i].mr;
            step();
            chk($sformatf("vec%0d count", i), WD'(count), WD'(vt[i].e_cnt));
            chk($sformatf("vec%0d m_valid", i), WD'(m_valid), WD'(vt[i].e_mv));
            chk($sformatf("vec%0d s_ready", i), WD'(s_ready), WD'(vt[i].e_sr));
            if (vt[i].chk_md)
                chk($sformatf("vec%0d m_data", i), m_data, vt[i].e_md);
        end

        // Back-to-back streaming with the sink always ready
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1; s_data = WD'(i);
            step();
            chk($sformatf("stream%0d m_data", i), m_data, WD'(i));
            chk($sformatf("stream%0d count", i), WD'(count), WD'(1));
            chk($sformatf("stream%0d m_valid", i), WD'(m_valid), WD'(1));
        end
        s_valid = 1'b0;
        step();
        chk("stream drain count", WD'(count), WD'(0));

        // Random stalls against a queue model
        begin
            logic [WD-1:0] q[$];
            int popped = 0;
            int cyc = 0;
            logic hold = 1'b0;
            logic stall;
            logic [WD-1:0] stall_data;
            logic push, pop;
            while (popped < 2000 && cyc < 20000) begin
                if (!hold) begin
                    s_valid = 1'($urandom_range(0, 1));
                    s_data  = $urandom;
                end
                m_ready = 1'($urandom_range(0, 1));
                push = s_valid & s_ready;
                pop  = m_valid & m_ready;
                if (pop) begin
                    if (q.size() == 0) begin
                        chk("rand pop from empty model", 32'd1, 32'd0);
                    end else begin
                        chk("rand m_data order", m_data, q[0]);
                        void'(q.pop_front());
                    end
                    popped++;
                end
                if (push) q.push_back(s_data);
                stall      = m_valid & ~m_ready;
                stall_data = m_data;
                hold       = s_valid & ~push;
                step();
                cyc++;
                chk("rand count vs model", WD'(count), WD'(q.size()));
                chk("rand count bound", WD'(count <= 2'd2), WD'(1));
                chk("rand m_valid vs model", WD'(m_valid), WD'(q.size() != 0));
                if (stall) begin
                    chk("rand stall m_valid held", WD'(m_valid), WD'(1));
                    chk("rand stall m_data held", m_data, stall_data);
                end
            end
            if (popped < 2000)
                chk("rand timeout words popped", WD'(popped), WD'(2000));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bw_pipe.md
# bw_pipe

Backward-registered pipe stage: a two-entry valid/ready register slice that breaks the combinational `m_ready` → `s_ready` path and also registers `m_valid` and `m_data`. It is the companion to the forward pipe, which registers the valid/data path but passes ready through combinationally. `bw_pipe` is placed in long handshake chains where the ready path limits timing. It sustains one transfer per cycle using an internal skid register.

## Interface
- `WD`, 8, data width in bits.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream data valid.
- `s_data`  in  `WD`  upstream data.
- `s_ready`  out  1  upstream ready; driven directly by a flop.
- `m_valid`  out  1  downstream valid; driven directly by a flop.
- `m_data`  out  `WD`  downstream data; driven directly by a flop.
- `m_ready`  in  1  downstream ready.
- `count`  out  2  occupancy, 0 to 2; a status output.

## Operation
- Push = `s_valid & s_ready`. Pop = `m_valid & m_ready`. Both are evaluated at the same edge.
- Storage:
  - Output register `out_q` drives `m_data`.
  - Skid register `skid_q` holds a second word.
- States, encoded by `count`:
  - EMPTY = 0
  - BUSY = 1
  - FULL = 2
- EMPTY:
  - Push: `out_q` ← `s_data`, go to BUSY.
  - Otherwise: stay in EMPTY.
- BUSY:
  - Push and pop: `out_q` ← `s_data`, stay in BUSY.
  - Push only: `skid_q` ← `s_data`, go to FULL.
  - Pop only: go to EMPTY.
  - Neither: hold.
- FULL (`s_ready` = 0, so no push is possible):
  - Pop: `out_q` ← `skid_q`, go to BUSY.
  - Otherwise: hold.
- Registered outputs:
  - `m_valid` = next-state ≠ EMPTY, registered.
  - `s_ready` = next-state ≠ FULL, registered.
- Ordering: words exit in arrival order. No word is dropped or duplicated.
- `s_valid` while `s_ready` = 0 is not a transfer. Upstream must hold its data; the block does not check this.
- `m_ready` may toggle freely. `m_valid` and `m_data` hold stable until popped.

## Timing
- Reset (`rst` = 1 at an edge), next-cycle values:
  - `count` = 0
  - `m_valid` = 0
  - `s_ready` = 0
  - `m_data` = 0
  - `skid_q` = 0
- After reset: `s_ready` rises to 1 at the first edge with `rst` = 0.
- Handshakes while `rst` = 1 are ignored.
- Reset mid-operation: stored words are discarded, with the same reset values as above.
- Latency: a push at edge N presents the word on `m_data` with `m_valid` = 1 after edge N, i.e. one cycle.
- Throughput: one word per cycle while `m_ready` = 1.
- Backpressure: when `m_ready` falls, at most one more word is accepted. `s_ready` falls one cycle after FULL is entered by that push, i.e. in the cycle following the edge.
- Release: a pop in FULL raises `s_ready` after that edge. Pushes resume the next cycle.
- No combinational path from any input to any output.

## Test plan
- Reset release:
  - Stimulus: hold `rst` = 1 for 3 cycles, then drop it.
  - Required: `m_valid` = 0, `s_ready` = 0, `count` = 0 during reset; `s_ready` = 1 one edge later.
- Streaming:
  - Stimulus: `m_ready` = 1, push 0x01..0x10 back-to-back.
  - Required: `m_data` shows 0x01..0x10 on consecutive cycles, one cycle after each push; `count` stays 1.
- Skid:
  - Stimulus: stream 0xA0, 0xA1, 0xA2…; drop `m_ready` while 0xA0 is on `m_data`.
  - Required: 0xA1 is accepted into skid; `count` = 2; `s_ready` = 0 next cycle; 0xA2 is held upstream.
  - Stimulus: raise `m_ready`.
  - Required: output order is 0xA0, 0xA1, 0xA2 with no gaps beyond 1 cycle.
- Random stall:
  - Stimulus: random `s_valid`/`m_ready`, 50% each, 2000 words, WD = 32.
  - Required:
    - scoreboard output matches input exactly;
    - `count` never exceeds 2;
    - `m_data` is stable whenever `m_valid & ~m_ready`.
- Mid-reset:
  - Stimulus: fill to FULL with 0x55, 0x66, then pulse `rst` for 1 cycle.
  - Required:
    - `count` = 0, `m_valid` = 0 after the edge;
    - a subsequent push of 0x77 appears alone on `m_data`; 0x55 and 0x66 are never output.
